uc_seq: RTL

//  Control unit and run/step/halt sequencer for the single-cycle microcontroller datapath.

---
 rtl/uc_seq_if.sv | 33 +++
 rtl/uc_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uc_seq_if.sv
// ---------------------------------------------------------------------------
// uc_seq_if
// Control bus between the uc_seq control unit and the single-cycle datapath.
//   Opcode  [5:0]  datapath -> control : instr[15:10]
//   z              datapath -> control : registered zero flag
//   s_inc          control -> datapath : PC mux select (0 = PC+1, 1 = jump target)
//   s_inm          control -> datapath : immediate operand / WA3 as read addr 2
//   we3            control -> datapath : register file write enable
//   wez            control -> datapath : zero flag write enable
//   Op     [2:0]   control -> datapath : ALU operation
//   pc_en          control -> datapath : PC register load enable
// Modports: master = control unit, slave = datapath.
// ---------------------------------------------------------------------------
interface uc_seq_if;
  logic [5:0] Opcode;
  logic       z;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] Op;
  logic       pc_en;

  modport master (
    input  Opcode, z,
    output s_inc, s_inm, we3, wez, Op, pc_en
  );

  modport slave (
    output Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, pc_en
  );
endinterface

// File: rtl/uc_seq.sv
// ---------------------------------------------------------------------------
// uc_seq
// Control unit plus run/step/halt sequencer for the single-cycle
// microcontroller datapath. Decodes Opcode/z into datapath controls during
// execute cycles, sequences BOOT / RUN / PAUSED / STEP / HALTED, and keeps a
// saturating retired-instruction counter.
//
// Parameters
//   CNT_W    width of the retired-instruction counter (default 16)
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   dp       uc_seq_if.master : Opcode/z in, s_inc/s_inm/we3/wez/Op/pc_en out
//   run      in   level: 1 = free-run, 0 = pause
//   step     in   pulse: execute one instruction while paused
//   resume   in   pulse: leave HALTED
//   halted   out  1 while in HALTED
//   paused   out  1 while in PAUSED
//   illegal  out  undefined Opcode decoded (held while trapped, see below)
//   icount   out  retired instructions, saturating
// Build option
//   UC_ILLEGAL_TRAP_EN : when defined, an undefined Opcode halts the sequencer
//   with the PC held, illegal stays high until resume/reset and the
//   instruction is not counted. When undefined, it runs as a counted NOP and
//   illegal pulses for that cycle only.
// ---------------------------------------------------------------------------
module uc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  uc_seq_if.master         dp,
  input  logic             run,
  input  logic             step,
  input  logic             resume,
  output logic             halted,
  output logic             paused,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] icount_reg, icount_next;

  // Opcode classification
  logic is_alu, is_nop, is_li, is_addi, is_j, is_jz, is_jnz, is_halt, is_undef;
  logic exec;
  logic trap_hit;

  always_comb begin
    is_alu   = dp.Opcode[5];
    is_nop   = (dp.Opcode == 6'b000000);
    is_li    = (dp.Opcode == 6'b000001);
    is_addi  = (dp.Opcode == 6'b000010);
    is_j     = (dp.Opcode == 6'b001000);
    is_jz    = (dp.Opcode == 6'b001001);
    is_jnz   = (dp.Opcode == 6'b001010);
    is_halt  = (dp.Opcode == 6'b001111);
    is_undef = ~(is_alu | is_nop | is_li | is_addi | is_j | is_jz | is_jnz | is_halt);
  end

  // Only RUN and STEP cycles actually execute the instruction on the bus.
  assign exec = (state_reg == S_RUN) || (state_reg == S_STEP);

`ifdef UC_ILLEGAL_TRAP_EN
  logic trap_reg, trap_next;

  assign trap_hit = exec & is_undef;

  // Remembers that HALTED was entered through an illegal opcode so the
  // illegal flag can be held until the operator resumes.
  always_comb begin
    trap_next = trap_reg;
    if (trap_hit) begin
      trap_next = 1'b1;
    end else if ((state_reg == S_HALTED) && resume) begin
      trap_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_reg <= 1'b0;
    end else begin
      trap_reg <= trap_next;
    end
  end
`else
  assign trap_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_BOOT: begin
        state_next = run ? S_RUN : S_PAUSED;
      end
      S_RUN: begin
        if (is_halt || trap_hit) begin
          state_next = S_HALTED;
        end else if (!run) begin
          state_next = S_PAUSED;
        end
      end
      S_PAUSED: begin
        // run has priority over a simultaneous step
        if (run) begin
          state_next = S_RUN;
        end else if (step) begin
          state_next = S_STEP;
        end
      end
      S_STEP: begin
        state_next = (is_halt || trap_hit) ? S_HALTED : S_PAUSED;
      end
      S_HALTED: begin
        if (resume) begin
          state_next = run ? S_RUN : S_PAUSED;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  // Output logic: decode is only meaningful while executing.
  always_comb begin
    dp.s_inc = 1'b0;
    dp.s_inm = 1'b0;
    dp.we3   = 1'b0;
    dp.wez   = 1'b0;
    dp.Op    = 3'b000;
    dp.pc_en = 1'b0;
    halted   = (state_reg == S_HALTED);
    paused   = (state_reg == S_PAUSED);
    illegal  = 1'b0;

    if (exec) begin
      // HALT and a trapping illegal keep the PC on the offending word.
      dp.pc_en = ~is_halt & ~trap_hit;
      illegal  = is_undef;
      if (is_alu) begin
        dp.Op  = dp.Opcode[4:2];
        dp.we3 = 1'b1;
        dp.wez = 1'b1;
      end else if (is_li) begin
        dp.s_inm = 1'b1;
        dp.we3   = 1'b1;
      end else if (is_addi) begin
        dp.s_inm = 1'b1;
        dp.Op    = 3'b010;
        dp.we3   = 1'b1;
        dp.wez   = 1'b1;
      end else if (is_j) begin
        dp.s_inc = 1'b1;
      end else if (is_jz) begin
        dp.s_inc = dp.z;
      end else if (is_jnz) begin
        dp.s_inc = ~dp.z;
      end
    end else if ((state_reg == S_HALTED) && resume) begin
      // Resume steps the PC off the HALT word with a plain increment.
      dp.pc_en = 1'b1;
    end

`ifdef UC_ILLEGAL_TRAP_EN
    if (trap_reg) begin
      illegal = 1'b1;
    end
`endif
  end

  // Retired-instruction counter: HALT does not retire, neither does a
  // trapping illegal opcode.
  always_comb begin
    icount_next = icount_reg;
    if (exec && !is_halt && !trap_hit && (icount_reg != {CNT_W{1'b1}})) begin
      icount_next = icount_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icount_reg <= '0;
    end else begin
      icount_reg <= icount_next;
    end
  end

  assign icount = icount_reg;

endmodule
